// File: rtl/cnn_maxpool_reader_if.sv
// Bundles the conv-RAM read port and the pooled-result valid/ready stream of cnn_maxpool_reader.
// master = the pooling reader, slave = RAM plus downstream consumer.
interface cnn_maxpool_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int FILT_W = 2
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [FILT_W-1:0] out_filt;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_filt,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_filt,
        output rd_data, out_ready
    );
endinterface

// File: rtl/cnn_maxpool_reader.sv
// 2x2 stride-2 max pooling over the conv feature-map RAM, one filter per output, valid/ready result stream.
// Define POOL_RELU_EN to clamp each pooled result to max(result, 0) (fused ReLU).
module cnn_maxpool_reader #(
    parameter int DATA_W   = 16,
    parameter int FMAP_W   = 26,
    parameter int FMAP_H   = 26,
    parameter int NUM_FILT = 4,
    parameter int ADDR_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pool_start,
    output logic                  busy,
    output logic                  pool_done,
    cnn_maxpool_reader_if.master  bus
);
    localparam int PH     = FMAP_H / 2;
    localparam int PW     = FMAP_W / 2;
    localparam int FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int PR_W   = (PH > 1) ? $clog2(PH) : 1;
    localparam int PC_W   = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, DONE} state_t;

    state_t                     state;
    logic [1:0]                 tap;
    logic [PR_W-1:0]            pr, nxt_pr;
    logic [PC_W-1:0]            pc, nxt_pc;
    logic [FILT_W-1:0]          filt, nxt_filt;
    logic signed [DATA_W-1:0]   run_max, pool_max, rd_s;
    logic                       last_filt, last_pc, last_pr, last_out;

    // Taps k=0..3 walk the 2x2 window row-major; odd trailing rows/cols are never addressed.
    function automatic logic [ADDR_W-1:0] tap_addr(input int r0, input int c0, input int f, input int k);
        int a;
        a = ((2*r0 + k/2)*FMAP_W + 2*c0 + k%2)*NUM_FILT + f;
        return a[ADDR_W-1:0];
    endfunction

    assign rd_s     = $signed(bus.rd_data);
    assign pool_max = (rd_s > run_max) ? rd_s : run_max;

    always_comb begin
        last_filt = (filt == FILT_W'(NUM_FILT-1));
        last_pc   = (pc == PC_W'(PW-1));
        last_pr   = (pr == PR_W'(PH-1));
        last_out  = last_filt && last_pc && last_pr;
        nxt_filt  = last_filt ? '0 : filt + 1'b1;
        nxt_pc    = last_filt ? (last_pc ? '0 : pc + 1'b1) : pc;
        nxt_pr    = (last_filt && last_pc) ? pr + 1'b1 : pr;
    end

    // NOTE: all state below is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: reset clears every register, data path included, so outputs read 0 right after reset.
            state         <= IDLE;
            tap           <= '0;
            pr            <= '0;
            pc            <= '0;
            filt          <= '0;
            run_max       <= '0;
            busy          <= 1'b0;
            pool_done     <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_filt  <= '0;
        end else begin
            pool_done <= 1'b0;
            case (state)
                IDLE: if (pool_start) begin
                    state       <= ISSUE;
                    busy        <= 1'b1;
                    tap         <= '0;
                    pr          <= '0;
                    pc          <= '0;
                    filt        <= '0;
                    bus.rd_en   <= 1'b1;
                    bus.rd_addr <= tap_addr(0, 0, 0, 0);
                end
                ISSUE: begin
                    // Read data lags the address by one cycle: at tap k we capture tap k-1.
                    if (tap != 2'd0)
                        run_max <= (tap == 2'd1 || rd_s > run_max) ? rd_s : run_max;
                    if (tap == 2'd3) begin
                        bus.rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        tap         <= tap + 2'd1;
                        bus.rd_addr <= tap_addr(int'(pr), int'(pc), int'(filt), int'(tap) + 1);
                    end
                end
                DRAIN: begin
`ifdef POOL_RELU_EN
                    bus.out_data <= pool_max[DATA_W-1] ? '0 : pool_max;
`else
                    bus.out_data <= pool_max;
`endif
                    bus.out_filt  <= filt;
                    bus.out_valid <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    if (last_out) begin
                        state     <= DONE;
                        pool_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        pr          <= nxt_pr;
                        pc          <= nxt_pc;
                        filt        <= nxt_filt;
                        tap         <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= tap_addr(int'(nxt_pr), int'(nxt_pc), int'(nxt_filt), 0);
                        state       <= ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_maxpool_reader.sv
// Randomized bench for cnn_maxpool_reader: a 4x4x2 instance and a 5x5x2 instance, each with a RAM model,
// checked against a window-max reference computed directly from the RAM contents.
module tb_cnn_maxpool_reader;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int FW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    cnn_maxpool_reader_if #(.DATA_W(DW), .ADDR_W(AW), .FILT_W(FW)) if_a ();
    cnn_maxpool_reader_if #(.DATA_W(DW), .ADDR_W(AW), .FILT_W(FW)) if_b ();

    cnn_maxpool_reader #(.DATA_W(DW), .FMAP_W(4), .FMAP_H(4), .NUM_FILT(2), .ADDR_W(AW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pool_start(start_a), .busy(busy_a), .pool_done(done_a), .bus(if_a));
    cnn_maxpool_reader #(.DATA_W(DW), .FMAP_W(5), .FMAP_H(5), .NUM_FILT(2), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pool_start(start_b), .busy(busy_b), .pool_done(done_b), .bus(if_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_err = 0;
    int mem_a[32];
    int mem_b[50];
    int bad_b = 0;

    // RAM models: data valid exactly one cycle after rd_en.
    always @(posedge clk) begin
        if (if_a.rd_en) if_a.rd_data <= 16'(mem_a[int'(if_a.rd_addr) % 32]);
        if (if_b.rd_en) begin
            if (int'(if_b.rd_addr) < 50) if_b.rd_data <= 16'(mem_b[int'(if_b.rd_addr)]);
            if (int'(if_b.rd_addr) >= 50 || (int'(if_b.rd_addr) / 2) / 5 == 4 || (int'(if_b.rd_addr) / 2) % 5 == 4)
                bad_b++;
        end
    end

    // Ready policy: 0 always, 1 one-of-three cycles, 2 random, 4 driven manually by the main sequence.
    int rdy_mode = 0;
    initial begin
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode != 4) begin
                if_a.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
                if_b.out_ready = if_a.out_ready;
            end
        end
    end

    int q_d[$], q_f[$], hs_cyc[$], exp_d[$], exp_f[$];
    int n_done = 0, done_cyc = -1, busy_at_done = -1, unstable = 0;
    int t0 = 1 << 30;
    logic [7:0] rd_bits, val_bits, busy_bits;
    logic held = 1'b0;
    logic [DW-1:0] held_data;
    logic [FW-1:0] held_filt;

    always @(negedge clk) begin
        if (if_a.out_valid && if_a.out_ready) begin
            q_d.push_back(int'($signed(if_a.out_data)));
            q_f.push_back(int'(if_a.out_filt));
            hs_cyc.push_back(cyc);
        end
        if (if_b.out_valid && if_b.out_ready) begin
            q_d.push_back(int'($signed(if_b.out_data)));
            q_f.push_back(int'(if_b.out_filt));
            hs_cyc.push_back(cyc);
        end
        if (held && (!if_a.out_valid || if_a.out_data != held_data || if_a.out_filt != held_filt))
            unstable++;
        held      = rst_n && if_a.out_valid && !if_a.out_ready;
        held_data = if_a.out_data;
        held_filt = if_a.out_filt;
        if (done_a || done_b) begin
            n_done++;
            done_cyc     = cyc;
            busy_at_done = int'(busy_a || busy_b);
        end
        if (cyc >= t0 && cyc < t0 + 8) begin
            rd_bits[cyc-t0]   = if_a.rd_en;
            val_bits[cyc-t0]  = if_a.out_valid;
            busy_bits[cyc-t0] = busy_a;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mem_rd(input bit sel, input int idx);
        return sel ? mem_b[idx] : mem_a[idx];
    endfunction

    // Reference: max of each 2x2 window per filter, in (pr, pc, filt) order.
    function automatic void build_exp(input bit sel, input int w, input int h);
        int m, v;
        exp_d.delete();
        exp_f.delete();
        for (int pr = 0; pr < h / 2; pr++)
            for (int pc = 0; pc < w / 2; pc++)
                for (int f = 0; f < 2; f++) begin
                    m = mem_rd(sel, ((2*pr)*w + 2*pc)*2 + f);
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = mem_rd(sel, ((2*pr + dr)*w + 2*pc + dc)*2 + f);
                            if (v > m) m = v;
                        end
`ifdef POOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    exp_d.push_back(m);
                    exp_f.push_back(f);
                end
    endfunction

    task automatic compare_exp(input string tag);
        check({tag, "_count"}, q_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < q_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), q_d[i], exp_d[i]);
            check($sformatf("%s_filt%0d", tag, i), q_f[i], exp_f[i]);
        end
    endtask

    task automatic start_run(input bit sel, input bit track);
        @(posedge clk);
        #1;
        q_d.delete();
        q_f.delete();
        hs_cyc.delete();
        n_done   = 0;
        unstable = 0;
        if (track) t0 = cyc + 1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 800 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_done > 0) ok = 1'b1;
        end
        check({tag, "_done_seen"}, int'(ok), 1);
        repeat (12) @(negedge clk);
    endtask

    task automatic fill_random(input bit sel);
        for (int i = 0; i < 50; i++) begin
            if (sel) mem_b[i] = int'($urandom_range(0, 65535)) - 32768;
            else if (i < 32) mem_a[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    int t1_exp[8] = '{10, 11, 14, 15, 26, 27, 30, 31};
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", int'(if_a.rd_en), 0);
        check("rst_out_valid", int'(if_a.out_valid), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp fill, ready always high: fixed expected sequence and timing.
        for (int i = 0; i < 32; i++) mem_a[i] = i;
        rdy_mode = 0;
        start_run(1'b0, 1'b1);
        wait_done("t1");
        exp_d.delete();
        exp_f.delete();
        for (int i = 0; i < 8; i++) begin
            exp_d.push_back(t1_exp[i]);
            exp_f.push_back(i % 2);
        end
        compare_exp("t1");
        check("t1_rd_en_pattern", int'(rd_bits), int'(8'b1100_1111));
        check("t1_valid_pattern", int'(val_bits), int'(8'b0010_0000));
        check("t1_busy_pattern", int'(busy_bits), int'(8'hFF));
        if (hs_cyc.size() == 8) begin
            check("t1_period", hs_cyc[1] - hs_cyc[0], 6);
            check("t1_done_latency", done_cyc, hs_cyc[7] + 1);
        end
        check("t1_done_count", n_done, 1);
        check("t1_busy_at_done", busy_at_done, 0);

        // Same fill, ready one cycle in three: same sequence, outputs held stable while stalled.
        rdy_mode = 1;
        start_run(1'b0, 1'b0);
        wait_done("t2");
        compare_exp("t2");
        check("t2_stable", unstable, 0);
        check("t2_done_count", n_done, 1);

        // All-negative window and tie window in an otherwise random map.
        fill_random(1'b0);
        mem_a[0] = -5; mem_a[2] = -2; mem_a[8] = -9; mem_a[10] = -3;
        rdy_mode = 2;
        start_run(1'b0, 1'b0);
        wait_done("t3neg");
        build_exp(1'b0, 4, 4);
        compare_exp("t3neg");
`ifdef POOL_RELU_EN
        if (q_d.size() > 0) check("t3_neg_window", q_d[0], 0);
`else
        if (q_d.size() > 0) check("t3_neg_window", q_d[0], -2);
`endif
        check("t3_stable", unstable, 0);
        mem_a[0] = 7; mem_a[2] = 7; mem_a[8] = 7; mem_a[10] = 7;
        start_run(1'b0, 1'b0);
        wait_done("t3tie");
        if (q_d.size() > 0) check("t3_tie_window", q_d[0], 7);

        // Random maps with random backpressure.
        for (int it = 0; it < 3; it++) begin
            fill_random(1'b0);
            start_run(1'b0, 1'b0);
            wait_done($sformatf("rnd%0d", it));
            build_exp(1'b0, 4, 4);
            compare_exp($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_stable", it), unstable, 0);
        end

        // Odd 5x5 map: trailing row/col never read.
        fill_random(1'b1);
        rdy_mode = 0;
        bad_b = 0;
        start_run(1'b1, 1'b0);
        wait_done("t4");
        build_exp(1'b1, 5, 5);
        compare_exp("t4");
        check("t4_bad_addr", bad_b, 0);
        check("t4_done_count", n_done, 1);

        // Extra pool_start pulses while busy are ignored.
        fill_random(1'b0);
        start_run(1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (20) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_done("t5");
        build_exp(1'b0, 4, 4);
        compare_exp("t5");
        check("t5_done_count", n_done, 1);
        check("t5_rd_en_pattern", int'(rd_bits), int'(8'b1100_1111));
        check("t5_valid_pattern", int'(val_bits), int'(8'b0010_0000));

        // Reset while the third output is being offered.
        rdy_mode = 4;
        if_a.out_ready = 1'b1;
        start_run(1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (q_d.size() >= 2) seen = 1'b1;
        end
        if_a.out_ready = 1'b0;
        check("t6_two_outputs", int'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (if_a.out_valid) seen = 1'b1;
        end
        check("t6_third_valid", int'(seen), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_rd_en", int'(if_a.rd_en), 0);
        check("t6_rd_addr", int'(if_a.rd_addr), 0);
        check("t6_out_valid", int'(if_a.out_valid), 0);
        check("t6_out_data", int'(if_a.out_data), 0);
        check("t6_out_filt", int'(if_a.out_filt), 0);
        check("t6_busy", int'(busy_a), 0);
        repeat (20) @(negedge clk);
        check("t6_no_done", n_done, 0);
        check("t6_count_after_abort", q_d.size(), 2);
        rdy_mode = 0;
        start_run(1'b0, 1'b0);
        wait_done("t6restart");
        compare_exp("t6restart");
        check("t6_restart_done_count", n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
